// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC source controller: FSM states, instruction
// classes, PC mux select codes and the RESOLVE-stage branch decision helper.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_RESOLVE  = 3'd3,
    ST_EXC_SAVE = 3'd4,
    ST_EXC_JUMP = 3'd5
  } state_e;

  localparam logic [2:0] OP_SEQ = 3'b000;
  localparam logic [2:0] OP_BEQ = 3'b001;
  localparam logic [2:0] OP_BNE = 3'b010;
  localparam logic [2:0] OP_J   = 3'b011;
  localparam logic [2:0] OP_JR  = 3'b100;

  localparam logic [2:0] SRC_PC4    = 3'b000;
  localparam logic [2:0] SRC_BRANCH = 3'b001;
  localparam logic [2:0] SRC_JUMP   = 3'b010;
  localparam logic [2:0] SRC_REG    = 3'b011;
  localparam logic [2:0] SRC_EXC    = 3'b100;

  typedef struct packed {
    logic       take;
    logic       illegal;
    logic [2:0] src;
  } resolve_t;

  // Turns a latched class/zero pair into "load PC or not" and the mux select.
  function automatic resolve_t resolve_op(input logic [2:0] op, input logic zero_f);
    resolve_t r;
    r = '{take: 1'b0, illegal: 1'b0, src: SRC_PC4};
    case (op)
      OP_SEQ: r.take = 1'b0;
      OP_BEQ: if (zero_f) begin
        r.take = 1'b1;
        r.src  = SRC_BRANCH;
      end
      OP_BNE: if (!zero_f) begin
        r.take = 1'b1;
        r.src  = SRC_BRANCH;
      end
      OP_J: begin
        r.take = 1'b1;
        r.src  = SRC_JUMP;
      end
      OP_JR: begin
        r.take = 1'b1;
        r.src  = SRC_REG;
      end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_wait_timer.sv
// Fetch wait counter: counts enabled cycles and flags the cycle in which the
// LIMIT-th consecutive wait cycle is being spent.
module pc_wait_timer #(
  parameter int TMR_W = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(LIMIT - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_source_ctrl.sv
// Multicycle PC source controller. Define PCSRC_EXC_EN to enable fetch
// timeout, exc_req handling, illegal-class traps and the EPC/vector sequence.
module pc_source_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_ready,
  input  logic       op_valid,
  input  logic [2:0] op_class,
  input  logic       zero,
  input  logic       exc_req,
  output logic [2:0] PCSource_control,
  output logic       PCWrite,
  output logic       EPCWrite,
  output logic       busy
);

`ifdef PCSRC_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       zero_q, zero_d;
  logic       pcw_q, pcw_d;
  logic       epc_q, epc_d;
  logic [2:0] src_q, src_d;

  logic       exc;
  logic       tmr_en;
  logic       tmr_clr;
  logic       tmr_expired;
  resolve_t   res;

  // The counter is held at zero outside FETCH, so every FETCH starts fresh.
  assign tmr_clr = (state_q != ST_FETCH);
  assign tmr_en  = EXC_EN && (state_q == ST_FETCH) && !mem_ready;

  pc_wait_timer #(
    .TMR_W (TMR_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Strobes are decided here and registered, so no input reaches an output
  // combinationally; a strobe shows in the cycle after the deciding state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    zero_d  = zero_q;
    pcw_d   = 1'b0;
    epc_d   = 1'b0;
    src_d   = SRC_PC4;
    exc     = EXC_EN && exc_req;
    res     = resolve_op(op_q, zero_q);

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (exc || tmr_expired) begin
          state_d = ST_EXC_SAVE;
          epc_d   = 1'b1;
        end else if (mem_ready) begin
          state_d = ST_DECODE;
          pcw_d   = 1'b1;
        end
      end
      ST_DECODE: begin
        if (exc) begin
          state_d = ST_EXC_SAVE;
          epc_d   = 1'b1;
        end else if (op_valid) begin
          op_d    = op_class;
          zero_d  = zero;
          state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (exc || (EXC_EN && res.illegal)) begin
          state_d = ST_EXC_SAVE;
          epc_d   = 1'b1;
        end else begin
          state_d = ST_FETCH;
          pcw_d   = res.take;
          src_d   = res.src;
        end
      end
      ST_EXC_SAVE: begin
        state_d = ST_EXC_JUMP;
        pcw_d   = 1'b1;
        src_d   = SRC_EXC;
      end
      ST_EXC_JUMP: state_d = ST_FETCH;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SEQ;
      zero_q  <= 1'b0;
      pcw_q   <= 1'b0;
      epc_q   <= 1'b0;
      src_q   <= SRC_PC4;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
      pcw_q   <= pcw_d;
      epc_q   <= epc_d;
      src_q   <= src_d;
    end
  end

  assign PCWrite          = pcw_q;
  assign EPCWrite         = epc_q && EXC_EN;
  assign PCSource_control = src_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: doc/pc_source_ctrl.md
PC_SOURCE_CTRL -- requirements
Module: pc_source_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the maximum FETCH wait cycles before a fetch-timeout exception.
REQ-002 SHALL have parameter TMR_W, default 4, the timeout counter width; MEM_TIMEOUT SHALL fit in TMR_W bits.
REQ-003 SHALL have port clk, input, 1, the single system clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port mem_ready, input, 1, instruction memory has returned the fetched word this cycle.
REQ-006 SHALL have port op_valid, input, 1, decoder output is valid.
REQ-007 SHALL have port op_class, input, 3, instruction class: 000 SEQ, 001 BEQ, 010 BNE, 011 J, 100 JR; others are illegal.
REQ-008 SHALL have port zero, input, 1, ALU zero flag for branch compare.
REQ-009 SHALL have port exc_req, input, 1, external exception request (overflow or bad opcode).
REQ-010 SHALL have port PCSource_control, output, 3, select for the PC source mux: 000 PC+4, 001 branch target, 010 jump target, 011 register, 100 exception vector.
REQ-011 SHALL have port PCWrite, output, 1, PC load strobe.
REQ-012 SHALL have port EPCWrite, output, 1, EPC load strobe.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, FETCH, DECODE, RESOLVE, EXC_SAVE and EXC_JUMP.
REQ-015 IDLE SHALL go to FETCH on the first cycle after reset is released.
REQ-016 FETCH SHALL wait for mem_ready.
- On mem_ready: assert PCWrite for 1 cycle with PCSource_control=000, then go to DECODE.
REQ-017 FETCH SHALL count cycles without mem_ready.
- When the count reaches MEM_TIMEOUT, go to EXC_SAVE.
- The counter SHALL clear on entry to FETCH.
REQ-018 DECODE SHALL wait for op_valid, then latch op_class and zero and go to RESOLVE.
REQ-019 RESOLVE SHALL last exactly 1 cycle, using the latched op_class and zero:
- BEQ with zero=1: PCSource_control=001 and PCWrite=1.
- BNE with zero=0: PCSource_control=001 and PCWrite=1.
- BEQ/BNE otherwise: PCWrite=0.
- J: PCSource_control=010 and PCWrite=1.
- JR: PCSource_control=011 and PCWrite=1.
- SEQ: PCWrite=0.
- Next state: FETCH.
REQ-020 An illegal op_class latched in DECODE SHALL send RESOLVE to EXC_SAVE with PCWrite=0.
REQ-021 EXC_SAVE SHALL assert EPCWrite for 1 cycle, then go to EXC_JUMP.
REQ-022 EXC_JUMP SHALL assert PCSource_control=100 and PCWrite=1 for 1 cycle, then go to FETCH.
REQ-023 exc_req high in FETCH, DECODE or RESOLVE SHALL force the next state to EXC_SAVE and suppress that cycle's PCWrite.
- This includes exc_req arriving in the same cycle as mem_ready.
REQ-024 exc_req SHALL be ignored in EXC_SAVE and EXC_JUMP; exceptions are not nested.
REQ-025 PCSource_control SHALL hold 000 in every state and cycle not listed above.
REQ-026 PCWrite and EPCWrite SHALL never be high in the same cycle.
REQ-027 All outputs SHALL be registered or Moore-decoded from the state register; outputs SHALL have no combinational path from inputs.

Reset
REQ-028 reset_n low at a rising edge SHALL force, on that edge:
- state IDLE;
- timer 0;
- latched op_class 000;
- PCSource_control=000, PCWrite=0, EPCWrite=0 and busy=0.
REQ-029 Reset asserted mid-operation (any state) SHALL abort it with no further PCWrite or EPCWrite pulse.

Configuration
REQ-030 Macro PCSRC_EXC_EN defined SHALL enable all exception behaviour (REQ-017, REQ-020 to REQ-024).
REQ-031 Without PCSRC_EXC_EN:
- exc_req SHALL be ignored and the timeout SHALL be disabled (FETCH waits indefinitely);
- an illegal op_class SHALL behave as SEQ;
- EPCWrite SHALL be tied 0, and PCSource_control=100 SHALL never be produced;
- EXC_SAVE and EXC_JUMP SHALL be unreachable.

Structure
REQ-032 Package pc_ctrl_pkg SHALL hold the state encoding, op_class codes and PCSource select codes (000 to 100).
REQ-033 The timeout counter SHALL be a sub-module pc_wait_timer with inputs clr and en and output expired.

Verification
REQ-034 Reset and fetch: release reset, mem_ready=1 on the 3rd FETCH cycle -> one PCWrite pulse with PCSource_control=000, then busy stays 1 in DECODE.
REQ-035 Branches:
- BEQ with zero=1 -> RESOLVE gives PCWrite=1 and PCSource_control=001.
- BNE with zero=1 -> PCWrite=0 and the next state is FETCH.
REQ-036 JR (op_class=100) -> exactly one PCWrite with PCSource_control=011, and 3 cycles from DECODE op_valid to the next FETCH.
REQ-037 Timeout: MEM_TIMEOUT=15 and mem_ready held 0 -> EPCWrite on cycle 16, then PCWrite with PCSource_control=100 on cycle 17.
REQ-038 Simultaneous events: exc_req and mem_ready both high in FETCH -> no 000 PCWrite, and EPCWrite on the next cycle.
REQ-039 Mid-operation reset and macro off:
- reset_n low in EXC_SAVE -> no EXC_JUMP pulse and state IDLE.
- With the macro undefined, op_class=111 -> no exception and a return to FETCH.
